// File: rtl/msx_input_pkg.sv
// Shared types and helpers for the MSX general-purpose port input path.
// Holds the port idle pattern, the signed 8-bit saturation limits and the sat8 clamp.
package msx_input_pkg;

    typedef logic [1:0] nib_idx_t;

    typedef enum logic {
        OWN_JOY   = 1'b0,
        OWN_MOUSE = 1'b1
    } owner_t;

    localparam logic [5:0] JOY_IDLE = 6'h3F;
    localparam int         SAT_MAX  = 127;
    localparam int         SAT_MIN  = -128;

    // Clamp a 10-bit signed intermediate into the signed 8-bit range the MSX mouse protocol carries.
    function automatic logic [7:0] sat8(input logic signed [9:0] v);
        if (int'(v) > SAT_MAX) begin
            return 8'(SAT_MAX);
        end else if (int'(v) < SAT_MIN) begin
            return 8'(SAT_MIN);
        end
        return v[7:0];
    endfunction

endpackage

// File: rtl/msx_sat_accum8.sv
// Per-axis saturating motion accumulator feeding the MSX mouse nibble stream.
// MSX_MOUSE_ACCUM_EN defined: strobes add onto the held value; undefined: each strobe replaces it.
module msx_sat_accum8
    import msx_input_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       clr,
    input  logic       add_en,
    input  logic [8:0] delta,
    input  logic       invert,
    output logic [7:0] acc
);

    logic [7:0]        acc_q;
    logic [7:0]        acc_d;
    logic signed [9:0] deltaExt;
    logic signed [9:0] deltaAdj;
    logic signed [9:0] sum;

    // A clear coinciding with a strobe means the old value was just snapshotted,
    // so the fresh delta starts the next accumulation on its own.
    always_comb begin
        deltaExt = {delta[8], delta};
        deltaAdj = invert ? -deltaExt : deltaExt;
`ifdef MSX_MOUSE_ACCUM_EN
        sum = {{2{acc_q[7]}}, acc_q} + deltaAdj;
`else
        sum = deltaAdj;
`endif
        acc_d = acc_q;
        if (clr && add_en) begin
            acc_d = sat8(deltaAdj);
        end else if (clr) begin
            acc_d = '0;
        end else if (add_en) begin
            acc_d = sat8(sum);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/msx_mouse_port_ctrl.sv
// Arbitrates one MSX joystick port between a DB9 joystick and a PS/2 mouse and serves the
// 4-nibble MSX mouse protocol on STR toggles. Accumulation mode selected by MSX_MOUSE_ACCUM_EN.
module msx_mouse_port_ctrl
    import msx_input_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter bit INVERT_X    = 1'b0,
    parameter bit INVERT_Y    = 1'b0
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       mouse_strobe,
    input  logic [8:0] mouse_dx,
    input  logic [8:0] mouse_dy,
    input  logic [1:0] mouse_btn,
    input  logic [5:0] joy_in,
    input  logic       str,
    output logic [5:0] port_out,
    output logic       mouse_active
);

    localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC);

    owner_t        owner_q, owner_d;
    logic          strDly_q;
    nib_idx_t      idx_q, idx_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic [5:0]    portOut_q, portOut_d;
    logic [7:0]    snapX_q, snapX_d;
    logic [7:0]    snapY_q, snapY_d;
    logic [7:0]    accX, accY;
    logic [3:0]    nibble;
    logic          toggle;
    logic          mouseMode;
    logic          captureEn;

    // Ownership: a mouse packet always claims the port, any pressed joystick line releases it.
    always_comb begin
        owner_d = owner_q;
        if (mouse_strobe) begin
            owner_d = OWN_MOUSE;
        end else if (joy_in != JOY_IDLE) begin
            owner_d = OWN_JOY;
        end
    end

    assign mouseMode = (owner_d == OWN_MOUSE);
    assign toggle    = (str != strDly_q);
    assign captureEn = mouseMode && toggle && (idx_q == 2'd0);

    msx_sat_accum8 u_accX (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr     (captureEn),
        .add_en  (mouse_strobe),
        .delta   (mouse_dx),
        .invert  (INVERT_X),
        .acc     (accX)
    );

    msx_sat_accum8 u_accY (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr     (captureEn),
        .add_en  (mouse_strobe),
        .delta   (mouse_dy),
        .invert  (INVERT_Y),
        .acc     (accY)
    );

    // The first nibble is read from the live accumulator because the snapshot loads on that same edge.
    always_comb begin
        case (idx_q)
            2'd0:    nibble = accX[7:4];
            2'd1:    nibble = snapX_q[3:0];
            2'd2:    nibble = snapY_q[7:4];
            default: nibble = snapY_q[3:0];
        endcase
    end

    always_comb begin
        idx_d     = idx_q;
        timeout_d = timeout_q;
        portOut_d = portOut_q;
        snapX_d   = snapX_q;
        snapY_d   = snapY_q;
        if (!mouseMode) begin
            portOut_d = joy_in;
            idx_d     = '0;
            timeout_d = '0;
        end else begin
            portOut_d[5:4] = ~mouse_btn;
            if (toggle) begin
                idx_d          = idx_q + 2'd1;
                timeout_d      = TO_LOAD;
                portOut_d[3:0] = nibble;
                if (captureEn) begin
                    snapX_d = accX;
                    snapY_d = accY;
                end
            end else if (timeout_q != '0) begin
                timeout_d = timeout_q - TW'(1);
                if (timeout_q == TW'(1)) begin
                    idx_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            owner_q   <= OWN_JOY;
            strDly_q  <= 1'b0;
            idx_q     <= '0;
            timeout_q <= '0;
            portOut_q <= JOY_IDLE;
            snapX_q   <= '0;
            snapY_q   <= '0;
        end else begin
            owner_q   <= owner_d;
            strDly_q  <= str;
            idx_q     <= idx_d;
            timeout_q <= timeout_d;
            portOut_q <= portOut_d;
            snapX_q   <= snapX_d;
            snapY_q   <= snapY_d;
        end
    end

    assign port_out     = portOut_q;
    assign mouse_active = (owner_q == OWN_MOUSE);

endmodule
